cdb_arbiter: RTL and testbench



---
 rtl/cdb_pkg.sv | 34 +++
 rtl/cdb_result_fifo.sv | 49 ++++
 rtl/cdb_arbiter.sv | 111 +++++++++++
 tb/tb_cdb_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared CDB types, widths and the round-robin scan helper.
package cdb_pkg;

   localparam int CDB_TAG_W  = 5;
   localparam int CDB_DATA_W = 32;
   localparam int CDB_MAX_FU = 8;

   typedef struct packed {
      logic [CDB_TAG_W-1:0]  tag;
      logic [CDB_DATA_W-1:0] data;
      logic                  branch;
      logic                  taken;
   } cdb_entry_t;

   // Returns {found, index} of the first set bit scanning ptr, ptr+1, ... mod n.
   function automatic logic [3:0] rr_next(
      input logic [CDB_MAX_FU-1:0] req,
      input logic [2:0]            ptr,
      input int                    n
   );
      logic [3:0] r;
      int         k;
      r = '0;
      for (int i = CDB_MAX_FU - 1; i >= 0; i--) begin
         if (i < n) begin
            k = int'(ptr) + i;
            if (k >= n) k = k - n;
            if (req[k]) r = {1'b1, k[2:0]};
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/cdb_result_fifo.sv
// Per-FU result FIFO with occupancy count; flush empties it.
module cdb_result_fifo #(
   parameter int W     = 39,
   parameter int DEPTH = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               dout,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;

   assign dout = mem[head];

   always_ff @(posedge clock) begin
      if (push && !flush) mem[tail] <= din;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + PW'(1);
         if (pop)  head <= head + PW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB transmit arbiter: per-FU FIFOs, round-robin grant, registered bus.
// Define CDB_ARB_BRANCH_PRIO_EN to let branch heads win over non-branch heads.
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int NUM_FU    = 4,
   parameter int BUF_DEPTH = 2,
   parameter int TAG_W     = CDB_TAG_W,
   parameter int DATA_W    = CDB_DATA_W
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   input  logic [NUM_FU-1:0]        fu_valid,
   output logic [NUM_FU-1:0]        fu_ready,
   input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
   input  logic [NUM_FU*DATA_W-1:0] fu_data,
   input  logic [NUM_FU-1:0]        fu_branch,
   input  logic [NUM_FU-1:0]        fu_branch_taken,
   output logic [TAG_W-1:0]         Cdb_rd_tag,
   output logic                     Cdb_valid,
   output logic [DATA_W-1:0]        Cdb_data,
   output logic                     Cdb_branch,
   output logic                     Cdb_branch_taken
);

   localparam int ENT_W = TAG_W + DATA_W + 2;
   localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
   localparam int PTR_W = $clog2(NUM_FU);

   logic [ENT_W-1:0]      head [NUM_FU];
   logic [NUM_FU-1:0]     push;
   logic [NUM_FU-1:0]     pop;
   logic [NUM_FU-1:0]     nonempty;
   logic [NUM_FU-1:0]     br_head;
   logic [PTR_W-1:0]      rr_ptr;
   logic [CDB_MAX_FU-1:0] req;
   logic [3:0]            sel;
   logic                  grant;
   logic [2:0]            win;
   logic [3:0]            win_inc;
   logic [ENT_W-1:0]      win_ent;

   for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
      logic [CNT_W-1:0] count;

      assign fu_ready[i] = (count != CNT_W'(BUF_DEPTH));
      assign nonempty[i] = (count != '0);
      assign push[i]     = fu_valid[i] & fu_ready[i];
      assign br_head[i]  = head[i][1];

      cdb_result_fifo #(
         .W     (ENT_W),
         .DEPTH (BUF_DEPTH)
      ) u_fifo (
         .clock (clock),
         .reset (reset),
         .flush (flush),
         .push  (push[i]),
         .pop   (pop[i]),
         .din   ({fu_tag[i*TAG_W +: TAG_W],
                  fu_data[i*DATA_W +: DATA_W],
                  fu_branch[i],
                  fu_branch_taken[i]}),
         .dout  (head[i]),
         .count (count)
      );
   end

   always_comb begin
      req = '0;
      req[NUM_FU-1:0] = nonempty;
`ifdef CDB_ARB_BRANCH_PRIO_EN
      if (|(nonempty & br_head)) req[NUM_FU-1:0] = nonempty & br_head;
`endif
      sel     = rr_next(req, 3'(rr_ptr), NUM_FU);
      grant   = sel[3];
      win     = sel[2:0];
      win_inc = {1'b0, win} + 4'd1;
      if (win_inc == 4'(NUM_FU)) win_inc = '0;
      pop     = '0;
      win_ent = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         if (grant && win == 3'(i)) begin
            pop[i]  = 1'b1;
            win_ent = head[i];
         end
      end
   end

   // Flush overrides any grant; the FIFOs drop the pop themselves.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr_ptr           <= '0;
         Cdb_valid        <= 1'b0;
         Cdb_rd_tag       <= '0;
         Cdb_data         <= '0;
         Cdb_branch       <= 1'b0;
         Cdb_branch_taken <= 1'b0;
      end else if (flush) begin
         Cdb_valid <= 1'b0;
      end else if (grant) begin
         Cdb_valid <= 1'b1;
         {Cdb_rd_tag, Cdb_data, Cdb_branch, Cdb_branch_taken} <= win_ent;
         rr_ptr    <= PTR_W'(win_inc);
      end else begin
         Cdb_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed-vector bench for cdb_arbiter (NUM_FU=4, BUF_DEPTH=2).
module tb_cdb_arbiter;
   import cdb_pkg::*;

   logic        clock;
   logic        reset;
   logic        flush;
   logic [3:0]  fu_valid;
   logic [3:0]  fu_ready;
   logic [19:0] fu_tag;
   logic [127:0] fu_data;
   logic [3:0]  fu_branch;
   logic [3:0]  fu_branch_taken;
   logic [4:0]  Cdb_rd_tag;
   logic        Cdb_valid;
   logic [31:0] Cdb_data;
   logic        Cdb_branch;
   logic        Cdb_branch_taken;

   int checks;
   int errors;

   cdb_arbiter dut (
      .clock            (clock),
      .reset            (reset),
      .flush            (flush),
      .fu_valid         (fu_valid),
      .fu_ready         (fu_ready),
      .fu_tag           (fu_tag),
      .fu_data          (fu_data),
      .fu_branch        (fu_branch),
      .fu_branch_taken  (fu_branch_taken),
      .Cdb_rd_tag       (Cdb_rd_tag),
      .Cdb_valid        (Cdb_valid),
      .Cdb_data         (Cdb_data),
      .Cdb_branch       (Cdb_branch),
      .Cdb_branch_taken (Cdb_branch_taken)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string nm, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic cdb_entry_t mk(input logic [4:0] t, input logic br,
                                     input logic tk);
      cdb_entry_t e;
      e.tag    = t;
      e.data   = 32'hA500_0000 | 32'(t);
      e.branch = br;
      e.taken  = tk;
      return e;
   endfunction

   task automatic offer(input int i, input cdb_entry_t e);
      fu_valid[i]          = 1'b1;
      fu_tag[i*5 +: 5]     = e.tag;
      fu_data[i*32 +: 32]  = e.data;
      fu_branch[i]         = e.branch;
      fu_branch_taken[i]   = e.taken;
   endtask

   task automatic drop(input int i);
      fu_valid[i] = 1'b0;
   endtask

   task automatic expect_cdb(input string nm, input cdb_entry_t e);
      check({nm, "_valid"}, 64'(Cdb_valid), 64'd1);
      check({nm, "_tag"}, 64'(Cdb_rd_tag), 64'(e.tag));
      check({nm, "_data"}, 64'(Cdb_data), 64'(e.data));
      check({nm, "_br"}, 64'(Cdb_branch), 64'(e.branch));
      check({nm, "_tk"}, 64'(Cdb_branch_taken), 64'(e.taken));
   endtask

   task automatic expect_idle(input string nm);
      check({nm, "_valid"}, 64'(Cdb_valid), 64'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   cdb_entry_t e;
   cdb_entry_t first;
   cdb_entry_t second;

   initial begin
      checks          = 0;
      errors          = 0;
      reset           = 1'b1;
      flush           = 1'b0;
      fu_valid        = '0;
      fu_tag          = '0;
      fu_data         = '0;
      fu_branch       = '0;
      fu_branch_taken = '0;

      // reset state
      tick();
      tick();
      check("rst_valid", 64'(Cdb_valid), 64'd0);
      check("rst_tag", 64'(Cdb_rd_tag), 64'd0);
      check("rst_data", 64'(Cdb_data), 64'd0);
      check("rst_br", 64'(Cdb_branch), 64'd0);
      reset = 1'b0;
      #1;
      check("rst_ready", 64'(fu_ready), 64'hF);

      // single push on FU2: broadcast after edge k+1 only
      e      = mk(5'd7, 1'b0, 1'b0);
      e.data = 32'hDEAD_BEEF;
      offer(2, e);
      tick();
      expect_idle("single_k");
      drop(2);
      tick();
      expect_cdb("single_k1", e);
      tick();
      expect_idle("single_k2");

      // all four together from rr_ptr=0
      do_reset();
      for (int i = 0; i < 4; i++) offer(i, mk(5'(i + 1), 1'b0, 1'b0));
      tick();
      fu_valid = '0;
      expect_idle("all4_pre");
      for (int i = 0; i < 4; i++) begin
         tick();
         expect_cdb($sformatf("all4_%0d", i), mk(5'(i + 1), 1'b0, 1'b0));
      end
      tick();
      expect_idle("all4_post");
      check("all4_rr", 64'(dut.rr_ptr), 64'd0);

      // FU0 fills to BUF_DEPTH while FU1..3 hold the bus
      offer(0, mk(5'd30, 1'b0, 1'b0));
      tick();
      drop(0);
      tick();
      expect_cdb("full_pre", mk(5'd30, 1'b0, 1'b0));
      offer(0, mk(5'd10, 1'b0, 1'b0));
      for (int i = 1; i < 4; i++) offer(i, mk(5'(20 + i), 1'b0, 1'b0));
      tick();
      check("full_e1_rdy", 64'(fu_ready), 64'hF);
      for (int i = 1; i < 4; i++) drop(i);
      offer(0, mk(5'd11, 1'b0, 1'b0));
      tick();
      expect_cdb("full_e2", mk(5'd21, 1'b0, 1'b0));
      check("full_e2_rdy0", 64'(fu_ready[0]), 64'd0);
      offer(0, mk(5'd12, 1'b0, 1'b0));
      tick();
      expect_cdb("full_e3", mk(5'd22, 1'b0, 1'b0));
      check("full_e3_rdy0", 64'(fu_ready[0]), 64'd0);
      tick();
      expect_cdb("full_e4", mk(5'd23, 1'b0, 1'b0));
      tick();
      expect_cdb("full_e5", mk(5'd10, 1'b0, 1'b0));
      check("full_e5_rdy0", 64'(fu_ready[0]), 64'd1);
      tick();
      expect_cdb("full_e6", mk(5'd11, 1'b0, 1'b0));
      drop(0);
      tick();
      expect_cdb("full_e7", mk(5'd12, 1'b0, 1'b0));
      tick();
      expect_idle("full_post");

      // flush with FU1 holding two entries and an FU3 push
      do_reset();
      offer(0, mk(5'd50, 1'b0, 1'b0));
      offer(1, mk(5'd40, 1'b0, 1'b0));
      tick();
      drop(0);
      offer(1, mk(5'd41, 1'b0, 1'b0));
      tick();
      expect_cdb("fl_pre", mk(5'd50, 1'b0, 1'b0));
      check("fl_rdy1", 64'(fu_ready[1]), 64'd0);
      drop(1);
      offer(3, mk(5'd43, 1'b0, 1'b0));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drop(3);
      expect_idle("fl_e0");
      check("fl_ready", 64'(fu_ready), 64'hF);
      check("fl_rr", 64'(dut.rr_ptr), 64'd1);
      for (int i = 1; i < 5; i++) begin
         tick();
         expect_idle($sformatf("fl_e%0d", i));
      end

      // asynchronous reset with three entries still buffered
      offer(0, mk(5'd70, 1'b0, 1'b0));
      offer(1, mk(5'd71, 1'b1, 1'b1));
      offer(2, mk(5'd72, 1'b0, 1'b0));
      offer(3, mk(5'd73, 1'b0, 1'b0));
      tick();
      fu_valid = '0;
      tick();
      expect_cdb("ar_pre", mk(5'd71, 1'b1, 1'b1));
      #2;
      reset = 1'b1;
      #1;
      check("ar_valid", 64'(Cdb_valid), 64'd0);
      check("ar_tag", 64'(Cdb_rd_tag), 64'd0);
      check("ar_data", 64'(Cdb_data), 64'd0);
      check("ar_br", 64'(Cdb_branch), 64'd0);
      check("ar_tk", 64'(Cdb_branch_taken), 64'd0);
      tick();
      reset = 1'b0;
      #1;
      check("ar_ready", 64'(fu_ready), 64'hF);
      for (int i = 0; i < 4; i++) begin
         tick();
         expect_idle($sformatf("ar_post%0d", i));
      end

      // branch head versus non-branch head
      do_reset();
      offer(0, mk(5'd8, 1'b0, 1'b0));
      offer(2, mk(5'd9, 1'b1, 1'b1));
`ifdef CDB_ARB_BRANCH_PRIO_EN
      first  = mk(5'd9, 1'b1, 1'b1);
      second = mk(5'd8, 1'b0, 1'b0);
`else
      first  = mk(5'd8, 1'b0, 1'b0);
      second = mk(5'd9, 1'b1, 1'b1);
`endif
      tick();
      fu_valid = '0;
      tick();
      expect_cdb("bp_1st", first);
      tick();
      expect_cdb("bp_2nd", second);
      tick();
      expect_idle("bp_post");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
